// File: rtl/liteic_slave_node_read_qos_if.sv
// Crossbar-side and slave-side read channel bundle of one liteic slave node.
// The "slave" modport is the node's own view (it is the slave-side node of
// the crossbar); the "master" modport is the view of whatever drives it
// (crossbar matrix plus the attached AXI-lite slave).
interface liteic_slave_node_read_qos_if #(
  parameter int NUM_MST = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  // crossbar request side (one lane per master slot, flattened)
  logic [NUM_MST*ADDR_W-1:0] cbar_reqst_data_i;
  logic [NUM_MST*4-1:0]      cbar_reqst_arqos_i;
  logic [NUM_MST-1:0]        cbar_reqst_val_i;
  logic [NUM_MST-1:0]        cbar_reqst_rdy_o;
  // crossbar response side
  logic [NUM_MST-1:0]        cbar_resp_rdy_i;
  logic [NUM_MST-1:0]        cbar_resp_val_o;
  logic [DATA_W+1:0]         cbar_resp_data_o;
  // AXI-lite slave port
  logic [ADDR_W-1:0]         slv_ar_addr_o;
  logic                      slv_ar_valid_o;
  logic                      slv_ar_ready_i;
  logic [DATA_W-1:0]         slv_r_data_i;
  logic [1:0]                slv_r_resp_i;
  logic                      slv_r_valid_i;
  logic                      slv_r_ready_o;

  modport slave (
    input  cbar_reqst_data_i, cbar_reqst_arqos_i, cbar_reqst_val_i,
    output cbar_reqst_rdy_o,
    input  cbar_resp_rdy_i,
    output cbar_resp_val_o, cbar_resp_data_o,
    output slv_ar_addr_o, slv_ar_valid_o,
    input  slv_ar_ready_i,
    input  slv_r_data_i, slv_r_resp_i, slv_r_valid_i,
    output slv_r_ready_o
  );

  modport master (
    output cbar_reqst_data_i, cbar_reqst_arqos_i, cbar_reqst_val_i,
    input  cbar_reqst_rdy_o,
    output cbar_resp_rdy_i,
    input  cbar_resp_val_o, cbar_resp_data_o,
    input  slv_ar_addr_o, slv_ar_valid_o,
    output slv_ar_ready_i,
    output slv_r_data_i, slv_r_resp_i, slv_r_valid_i,
    input  slv_r_ready_o
  );
endinterface

// File: rtl/liteic_slave_node_read_qos.sv
// liteic slave-side read node: QoS arbitration of crossbar AR requests onto
// one AXI-lite slave, in-order routing of R beats back through a grant FIFO.
// Optional QoS aging of stalled requesters is built when LITEIC_QOS_AGING_EN
// is defined; without it the effective QoS is the raw ARQOS.
module liteic_slave_node_read_qos #(
  parameter int                 NUM_MST         = 4,
  parameter int                 ADDR_W          = 32,
  parameter int                 DATA_W          = 32,
  parameter int                 MAX_OUTSTANDING = 4,
  parameter logic [NUM_MST-1:0] CONNECTIVITY    = '1,
  parameter int                 AGE_PERIOD      = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  liteic_slave_node_read_qos_if.slave          bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic [4:0]                           grant_idx_o,
  output logic                                 r_orphan_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SEL_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  // registered state
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [SEL_W-1:0] r_fifo [MAX_OUTSTANDING];
  logic [SEL_W-1:0] r_rr_ptr;
  logic             r_lock;
  logic [SEL_W-1:0] r_lock_idx;
  logic [SEL_W-1:0] r_grant_idx;
  logic             r_orphan;

  // combinational signals
  logic [NUM_MST-1:0]      w_elig;
  logic [NUM_MST-1:0][3:0] w_eff_qos;
  logic                    w_any;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_arb_found;
  logic [SEL_W-1:0]        w_arb_idx;
  logic [3:0]              w_arb_qos;
  logic                    w_lock_live;
  logic [SEL_W-1:0]        w_grant;
  logic                    w_ar_valid;
  logic                    w_ar_hs;
  logic [SEL_W-1:0]        w_head;
  logic                    w_r_ready;
  logic                    w_r_hs;

  assign w_elig  = bus.cbar_reqst_val_i & CONNECTIVITY;
  assign w_any   = |w_elig;
  assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);

`ifdef LITEIC_QOS_AGING_EN
  localparam int AGE_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD+1) : 1;

  for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_age
    logic [AGE_W-1:0] r_stall;
    logic [3:0]       r_bonus;
    logic [4:0]       w_sum;

    assign w_sum         = {1'b0, bus.cbar_reqst_arqos_i[gi*4 +: 4]} + {1'b0, r_bonus};
    assign w_eff_qos[gi] = w_sum[4] ? 4'hF : w_sum[3:0];

    // Count stall cycles while waiting; each full period buys one QoS step.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_stall <= '0;
        r_bonus <= '0;
      end else if (!w_elig[gi] || (w_ar_hs && (w_grant == SEL_W'(gi)))) begin
        r_stall <= '0;
        r_bonus <= '0;
      end else if (r_stall == AGE_W'(AGE_PERIOD-1)) begin
        r_stall <= '0;
        if (r_bonus != 4'hF) r_bonus <= r_bonus + 1'b1;
      end else begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end
`else
  for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_qos
    assign w_eff_qos[gi] = bus.cbar_reqst_arqos_i[gi*4 +: 4];
  end
`endif

  // Highest effective QoS wins; strict '>' while scanning from rr_ptr keeps
  // the first tied slot in round-robin order.
  always_comb begin : p_arb
    int v_pos;
    v_pos       = 0;
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_arb_qos   = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      v_pos = int'(r_rr_ptr) + k;
      if (v_pos >= NUM_MST) v_pos = v_pos - NUM_MST;
      if (w_elig[SEL_W'(v_pos)] && (!w_arb_found || (w_eff_qos[SEL_W'(v_pos)] > w_arb_qos))) begin
        w_arb_found = 1'b1;
        w_arb_idx   = SEL_W'(v_pos);
        w_arb_qos   = w_eff_qos[SEL_W'(v_pos)];
      end
    end
  end

  // A stalled grant is held so the slave sees a stable address; the lock
  // only yields if the locked requester withdraws.
  assign w_lock_live = r_lock & w_elig[r_lock_idx];
  assign w_grant     = w_lock_live ? r_lock_idx : w_arb_idx;
  assign w_ar_valid  = w_any & ~w_full;
  assign w_ar_hs     = w_ar_valid & bus.slv_ar_ready_i;

  assign bus.slv_ar_valid_o = w_ar_valid;
  assign bus.slv_ar_addr_o  = bus.cbar_reqst_data_i[w_grant*ADDR_W +: ADDR_W];

  // R routing follows the oldest outstanding grant.
  assign w_head    = r_fifo[r_rd_ptr];
  assign w_r_ready = ~w_empty & bus.cbar_resp_rdy_i[w_head];
  assign w_r_hs    = bus.slv_r_valid_i & w_r_ready;

  assign bus.slv_r_ready_o    = w_r_ready;
  assign bus.cbar_resp_data_o = {bus.slv_r_data_i, bus.slv_r_resp_i};

  for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_lane
    assign bus.cbar_reqst_rdy_o[gi] = CONNECTIVITY[gi] & w_ar_hs & (w_grant == SEL_W'(gi));
    assign bus.cbar_resp_val_o[gi]  = CONNECTIVITY[gi] & bus.slv_r_valid_i & ~w_empty
                                      & (w_head == SEL_W'(gi));
  end

  // Grant FIFO storage; entries beyond the count are never read.
  always_ff @(posedge clk_i) begin
    if (w_ar_hs) r_fifo[r_wr_ptr] <= w_grant;
  end

  // FIFO pointers and in-flight count; reset flushes all in-flight reads.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_ar_hs)
        r_wr_ptr <= (r_wr_ptr == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_r_hs)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : r_rd_ptr + 1'b1;
      case ({w_ar_hs, w_r_hs})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Round-robin pointer, grant lock and last-grant index.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rr_ptr    <= '0;
      r_lock      <= 1'b0;
      r_lock_idx  <= '0;
      r_grant_idx <= '0;
    end else if (w_ar_hs) begin
      r_rr_ptr    <= (w_grant == SEL_W'(NUM_MST-1)) ? '0 : w_grant + 1'b1;
      r_grant_idx <= w_grant;
      r_lock      <= 1'b0;
    end else if (w_ar_valid) begin
      r_lock      <= 1'b1;
      r_lock_idx  <= w_grant;
    end else begin
      r_lock      <= 1'b0;
    end
  end

  // Sticky flag for a slave R beat arriving with nothing outstanding.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_orphan <= 1'b0;
    else if (bus.slv_r_valid_i && w_empty) r_orphan <= 1'b1;
  end

  assign outstanding_o = r_count;
  assign grant_idx_o   = 5'(r_grant_idx);
  assign r_orphan_o    = r_orphan;

endmodule

// File: tb/tb_liteic_slave_node_read_qos.sv
// Scoreboard bench for liteic_slave_node_read_qos (NUM_MST=4, MAX_OUTSTANDING=2,
// AGE_PERIOD=4). Expected AR grants are queued when requests are driven and
// checked at each AR handshake; each checked grant queues the slot that must
// receive the next R beat. Aging checks are built with LITEIC_QOS_AGING_EN.
module tb_liteic_slave_node_read_qos;

  localparam int NUM_MST = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 2;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic [1:0] outstanding_o;
  logic [4:0] grant_idx_o;
  logic       r_orphan_o;

  always #5 clk_i = ~clk_i;

  liteic_slave_node_read_qos_if #(.NUM_MST(NUM_MST), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  liteic_slave_node_read_qos #(
    .NUM_MST(NUM_MST), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MAX_OUTSTANDING(MAX_OUT), .CONNECTIVITY(4'b1111), .AGE_PERIOD(4)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .bus(bus),
    .outstanding_o(outstanding_o), .grant_idx_o(grant_idx_o), .r_orphan_o(r_orphan_o)
  );

  typedef struct {
    int          slot;
    logic [31:0] addr;
  } ar_exp_t;

  ar_exp_t ar_q[$];
  int      r_q[$];
  int      n_tests = 0;
  int      n_fail  = 0;
  bit      sb_en   = 1'b1;
  ar_exp_t mon_e;
  int      mon_s;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (rstn_i && sb_en) begin
      if (bus.slv_ar_valid_o && bus.slv_ar_ready_i) begin
        check("ar_expected", 64'(ar_q.size() != 0), 64'(1));
        if (ar_q.size() != 0) begin
          mon_e = ar_q.pop_front();
          check("ar_rdy_onehot", 64'(bus.cbar_reqst_rdy_o), 64'(1) << mon_e.slot);
          check("ar_addr", 64'(bus.slv_ar_addr_o), 64'(mon_e.addr));
          r_q.push_back(mon_e.slot);
          $display("[TB] AR slot %0d addr 0x%0h", mon_e.slot, bus.slv_ar_addr_o);
        end
      end
      if (bus.slv_r_valid_i && bus.slv_r_ready_o) begin
        check("r_expected", 64'(r_q.size() != 0), 64'(1));
        if (r_q.size() != 0) begin
          mon_s = r_q.pop_front();
          check("r_val_onehot", 64'(bus.cbar_resp_val_o), 64'(1) << mon_s);
          check("r_data", 64'(bus.cbar_resp_data_o), 64'({bus.slv_r_data_i, bus.slv_r_resp_i}));
          $display("[TB] R  slot %0d data 0x%0h resp %0d", mon_s, bus.slv_r_data_i, bus.slv_r_resp_i);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int s, input logic [31:0] a, input logic [3:0] q);
    bus.cbar_reqst_val_i[s]            = 1'b1;
    bus.cbar_reqst_data_i[s*32 +: 32]  = a;
    bus.cbar_reqst_arqos_i[s*4 +: 4]   = q;
  endtask

  task automatic push_exp(input int s, input logic [31:0] a);
    ar_exp_t e;
    e.slot = s;
    e.addr = a;
    ar_q.push_back(e);
  endtask

  task automatic req(input int s, input logic [31:0] a, input logic [3:0] q);
    set_req(s, a, q);
    push_exp(s, a);
  endtask

  // Wait (bounded) for slot s to be accepted, then withdraw its request.
  task automatic wait_ar_hs(input int s);
    bit got = 1'b0;
    int n   = 0;
    while (!got && n < 20) begin
      @(negedge clk_i);
      if (bus.cbar_reqst_rdy_o[s]) got = 1'b1;
      n++;
    end
    check($sformatf("ar_hs_slot%0d", s), 64'(got), 64'(1));
    tick();
    bus.cbar_reqst_val_i[s] = 1'b0;
  endtask

  // Present one slave R beat and wait (bounded) for it to be taken.
  task automatic r_beat(input logic [31:0] d, input logic [1:0] resp);
    bit got = 1'b0;
    int n   = 0;
    bus.slv_r_data_i  = d;
    bus.slv_r_resp_i  = resp;
    bus.slv_r_valid_i = 1'b1;
    while (!got && n < 20) begin
      @(negedge clk_i);
      if (bus.slv_r_ready_o) got = 1'b1;
      n++;
    end
    check("r_beat_taken", 64'(got), 64'(1));
    tick();
    bus.slv_r_valid_i = 1'b0;
  endtask

  initial begin
    rstn_i                 = 1'b0;
    bus.cbar_reqst_data_i  = '0;
    bus.cbar_reqst_arqos_i = '0;
    bus.cbar_reqst_val_i   = '0;
    bus.cbar_resp_rdy_i    = '0;
    bus.slv_ar_ready_i     = 1'b0;
    bus.slv_r_data_i       = '0;
    bus.slv_r_resp_i       = '0;
    bus.slv_r_valid_i      = 1'b0;
    tick();
    tick();
    @(negedge clk_i);
    check("rst_ar_valid", 64'(bus.slv_ar_valid_o), 64'(0));
    check("rst_r_ready", 64'(bus.slv_r_ready_o), 64'(0));
    check("rst_reqst_rdy", 64'(bus.cbar_reqst_rdy_o), 64'(0));
    check("rst_resp_val", 64'(bus.cbar_resp_val_o), 64'(0));
    check("rst_outstanding", 64'(outstanding_o), 64'(0));
    check("rst_grant_idx", 64'(grant_idx_o), 64'(0));
    check("rst_orphan", 64'(r_orphan_o), 64'(0));
    tick();
    rstn_i = 1'b1;
    tick();

    // Single read from slot 2
    bus.slv_ar_ready_i  = 1'b1;
    bus.cbar_resp_rdy_i = 4'b1111;
    req(2, 32'h100, 4'd3);
    #1;
    check("t1_out_before", 64'(outstanding_o), 64'(0));
    check("t1_ar_valid", 64'(bus.slv_ar_valid_o), 64'(1));
    check("t1_addr_same_cycle", 64'(bus.slv_ar_addr_o), 64'h100);
    wait_ar_hs(2);
    #1;
    check("t1_out_one", 64'(outstanding_o), 64'(1));
    check("t1_grant_idx", 64'(grant_idx_o), 64'(2));
    r_beat(32'hDEAD, 2'b00);
    #1;
    check("t1_out_zero", 64'(outstanding_o), 64'(0));

    // Warm-up read from slot 1 leaves rr_ptr at 2
    req(1, 32'h200, 4'd0);
    wait_ar_hs(1);
    r_beat(32'h1111, 2'b00);

    // QoS priority: slots 0/1/3 with qos 1/7/7 -> 3, 1, 0
    set_req(0, 32'h300, 4'd1);
    set_req(1, 32'h310, 4'd7);
    set_req(3, 32'h330, 4'd7);
    push_exp(3, 32'h330);
    push_exp(1, 32'h310);
    push_exp(0, 32'h300);
    wait_ar_hs(3);
    wait_ar_hs(1);
    #1;
    check("t2_full_blocks_ar", 64'(bus.slv_ar_valid_o), 64'(0));
    r_beat(32'h3333, 2'b00);
    wait_ar_hs(0);
    r_beat(32'h1111_0001, 2'b01);
    r_beat(32'h0000_0300, 2'b00);

    // Outstanding limit: third AR waits for the registered count to drop
    req(0, 32'h400, 4'd0);
    wait_ar_hs(0);
    req(1, 32'h410, 4'd0);
    wait_ar_hs(1);
    req(2, 32'h420, 4'd0);
    repeat (2) begin
      @(negedge clk_i);
      check("t3_ar_blocked", 64'(bus.slv_ar_valid_o), 64'(0));
    end
    @(posedge clk_i);
    #1;
    bus.slv_r_data_i  = 32'hA0;
    bus.slv_r_resp_i  = 2'b00;
    bus.slv_r_valid_i = 1'b1;
    @(negedge clk_i);
    check("t3_blocked_in_pop_cycle", 64'(bus.slv_ar_valid_o), 64'(0));
    @(posedge clk_i);
    #1;
    bus.slv_r_valid_i = 1'b0;
    @(negedge clk_i);
    check("t3_unblocked_after_pop", 64'(bus.slv_ar_valid_o), 64'(1));
    @(posedge clk_i);
    #1;
    bus.cbar_reqst_val_i[2] = 1'b0;
    r_beat(32'hB1, 2'b00);
    r_beat(32'hC2, 2'b00);
    #1;
    check("t3_out_drained", 64'(outstanding_o), 64'(0));

    // Grant lock: slot 0 stalled, slot 1 with higher qos must not preempt
    bus.slv_ar_ready_i = 1'b0;
    req(0, 32'h500, 4'd2);
    #1;
    check("t4_ar_valid", 64'(bus.slv_ar_valid_o), 64'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) req(1, 32'h510, 4'd9);
      #1;
      check("t4_lock_addr", 64'(bus.slv_ar_addr_o), 64'h500);
      check("t4_no_rdy_while_stalled", 64'(bus.cbar_reqst_rdy_o), 64'(0));
    end
    bus.slv_ar_ready_i = 1'b1;
    wait_ar_hs(0);
    wait_ar_hs(1);
    r_beat(32'h5000, 2'b00);
    r_beat(32'h5100, 2'b00);

    // Response backpressure: head slot not ready holds the beat
    req(3, 32'h600, 4'd4);
    wait_ar_hs(3);
    bus.slv_r_data_i    = 32'hBEEF;
    bus.slv_r_resp_i    = 2'b10;
    bus.slv_r_valid_i   = 1'b1;
    bus.cbar_resp_rdy_i = 4'b0111;
    repeat (2) begin
      @(negedge clk_i);
      check("t5_r_ready_low", 64'(bus.slv_r_ready_o), 64'(0));
      check("t5_resp_val_held", 64'(bus.cbar_resp_val_o), 64'(4'b1000));
      check("t5_out_held", 64'(outstanding_o), 64'(1));
    end
    @(posedge clk_i);
    #1;
    bus.cbar_resp_rdy_i = 4'b1111;
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    bus.slv_r_valid_i = 1'b0;
    #1;
    check("t5_out_zero", 64'(outstanding_o), 64'(0));

    // Orphan: R valid with nothing outstanding
    check("t6_orphan_clear", 64'(r_orphan_o), 64'(0));
    bus.slv_r_valid_i = 1'b1;
    #1;
    check("t6_no_resp_val", 64'(bus.cbar_resp_val_o), 64'(0));
    check("t6_no_r_ready", 64'(bus.slv_r_ready_o), 64'(0));
    tick();
    bus.slv_r_valid_i = 1'b0;
    #1;
    check("t6_orphan_set", 64'(r_orphan_o), 64'(1));
    tick();
    check("t6_orphan_sticky", 64'(r_orphan_o), 64'(1));

    // Reset with a read in flight forgets it
    req(1, 32'h700, 4'd5);
    wait_ar_hs(1);
    #1;
    check("t7_out_one", 64'(outstanding_o), 64'(1));
    rstn_i = 1'b0;
    #1;
    check("t7_out_flushed", 64'(outstanding_o), 64'(0));
    check("t7_grant_idx_rst", 64'(grant_idx_o), 64'(0));
    check("t7_orphan_rst", 64'(r_orphan_o), 64'(0));
    r_q.delete();
    tick();
    rstn_i = 1'b1;
    tick();
    bus.slv_r_data_i  = 32'h7777;
    bus.slv_r_valid_i = 1'b1;
    #1;
    check("t7_resp_forgotten", 64'(bus.cbar_resp_val_o), 64'(0));
    tick();
    bus.slv_r_valid_i = 1'b0;
    #1;
    check("t7_orphan_after_rst", 64'(r_orphan_o), 64'(1));

`ifdef LITEIC_QOS_AGING_EN
    // Aging: qos-0 slot 0 against a continuous qos-1 stream from slot 1
    begin
      bit got = 1'b0;
      int waited = 0;
      sb_en               = 1'b0;
      bus.slv_ar_ready_i  = 1'b1;
      bus.cbar_resp_rdy_i = 4'b1111;
      bus.slv_r_data_i    = 32'h66;
      bus.slv_r_valid_i   = 1'b1;
      set_req(1, 32'h810, 4'd1);
      set_req(0, 32'h800, 4'd0);
      while (!got && waited < 20) begin
        @(negedge clk_i);
        if (bus.cbar_reqst_rdy_o[0]) got = 1'b1;
        else waited++;
      end
      check("t8_aged_grant", 64'(got), 64'(1));
      check("t8_wait_le_8", 64'(waited <= 8), 64'(1));
      tick();
      bus.cbar_reqst_val_i = '0;
      repeat (4) tick();
      bus.slv_r_valid_i = 1'b0;
      tick();
      check("t8_out_drained", 64'(outstanding_o), 64'(0));
      sb_en = 1'b1;
    end
`endif

    check("sb_ar_queue_empty", 64'(ar_q.size()), 64'(0));
    check("sb_r_queue_empty", 64'(r_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/liteic_slave_node_read_qos.md
# liteic_slave_node_read_qos

Slave-side read node of the liteic AXI-lite crossbar: arbitrates AR requests from up to NUM_MST crossbar master slots onto one AXI-lite slave port and routes R responses back. Arbitration is by 4-bit ARQOS (highest wins) with round-robin tie-break. Up to MAX_OUTSTANDING reads may be in flight, tracked in an in-order grant FIFO. It sits between the crossbar matrix and one slave port, one instance per slave.

## Interface
- NUM_MST, 4: crossbar master slots (1..32).
- ADDR_W, 32: AR address width.
- DATA_W, 32: R data width; crossbar response word is DATA_W+2 bits, {r_data, r_resp}.
- MAX_OUTSTANDING, 4: in-flight reads (1..16); grant FIFO depth.
- CONNECTIVITY, all ones: NUM_MST-bit mask; bit i = 0 means slot i is not connected to this slave.
- AGE_PERIOD, 16: stall cycles per QoS aging step; used only with LITEIC_QOS_AGING_EN.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- cbar_reqst_data_i  in  ADDR_W x NUM_MST  per-slot AR address.
- cbar_reqst_arqos_i  in  4 x NUM_MST  per-slot ARQOS.
- cbar_reqst_val_i  in  NUM_MST  per-slot AR valid.
- cbar_reqst_rdy_o  out  NUM_MST  per-slot AR ready, one-hot or zero.
- cbar_resp_rdy_i  in  NUM_MST  per-slot R ready.
- cbar_resp_val_o  out  NUM_MST  per-slot R valid, one-hot or zero.
- cbar_resp_data_o  out  DATA_W+2  R word, broadcast to all slots.
- slv_ar_addr_o  out  ADDR_W  slave AR address.
- slv_ar_valid_o  out  1  slave AR valid.
- slv_ar_ready_i  in  1  slave AR ready.
- slv_r_data_i  in  DATA_W  slave R data.
- slv_r_resp_i  in  2  slave R response.
- slv_r_valid_i  in  1  slave R valid.
- slv_r_ready_o  out  1  slave R ready.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  reads in flight.
- grant_idx_o  out  5  slot index of the current or last AR grant.
- r_orphan_o  out  1  sticky flag: R valid seen while no read was outstanding.

## Operation
- Eligible slots: cbar_reqst_val_i[i] & CONNECTIVITY[i]. Unconnected slots always drive rdy and resp_val to 0.
- Arbitration when unlocked: choose the highest effective QoS. Break ties by the first eligible slot at or after rr_ptr, scanning upward and wrapping.
- Grant lock: if slv_ar_valid_o is 1 and slv_ar_ready_i is 0, register the granted index and hold it until handshake. The address stays stable; a higher-QoS arrival does not preempt.
- slv_ar_valid_o = any eligible slot & !fifo_full. slv_ar_addr_o = address of the granted slot. cbar_reqst_rdy_o = onehot(grant) & slv_ar_ready_i & !fifo_full.
- On AR handshake: push the grant index into the FIFO, set rr_ptr = grant+1 (mod NUM_MST), and update grant_idx_o.
- R path: head = FIFO head index. cbar_resp_val_o = onehot(head) & slv_r_valid_i & !fifo_empty. slv_r_ready_o = cbar_resp_rdy_i[head] & !fifo_empty. cbar_resp_data_o = {slv_r_data_i, slv_r_resp_i}.
- Pop on R handshake.
- Push and pop in the same cycle: the count is unchanged. Full is taken from the registered count, so a pop does not unblock AR until the next cycle.
- R valid while the FIFO is empty: the beat is not accepted and r_orphan_o sets. Only reset clears it.

## Timing
- AR: zero-cycle combinational path from cbar valid to slave valid. A grant completes in the cycle slv_ar_ready_i=1.
- R: zero-cycle pass-through in both directions.
- outstanding_o and the FIFO update on the clock edge after the handshake.
- Reset values: slv_ar_valid_o=0, slv_r_ready_o=0, cbar_reqst_rdy_o=0, cbar_resp_val_o=0, outstanding_o=0, grant_idx_o=0, r_orphan_o=0, rr_ptr=0, lock=0, aging counters=0.
- Reset asserted mid-transaction: the FIFO is flushed and in-flight reads are forgotten. Responses after reset are orphans.

## Configuration
- LITEIC_QOS_AGING_EN defined:
  - Each slot has a stall counter that increments every cycle the slot is eligible but not granted.
  - Every AGE_PERIOD stall cycles, the slot's effective QoS gains +1, saturating at 15.
  - The counter and bonus clear when the slot is granted or drops valid.
- Undefined: effective QoS = raw ARQOS, and no aging logic exists.

## Test plan
- Single read, NUM_MST=4: slot 2 requests addr 0x100 with qos 3 -> slv_ar_addr_o=0x100 in the same cycle. The R beat 0xDEAD/OKAY returns with cbar_resp_val_o=4'b0100, and outstanding_o goes 0→1→0.
- QoS priority: slots 0/1/3 request at once with qos 1/7/7, rr_ptr=2 -> grant order 3, 1, 0.
- Outstanding limit, MAX_OUTSTANDING=2: three reads from slots 0,1,2 with slave R held -> third AR blocked (slv_ar_valid_o=0). Releasing R returns responses to slots 0 then 1, and the third AR issues the cycle after the first pop.
- Grant lock: slot 0 (qos 2) is stalled by slv_ar_ready_i=0 for 3 cycles while slot 1 (qos 9) arrives -> slot 0 completes first and the address is stable throughout.
- Backpressure and orphan: cbar_resp_rdy_i[head]=0 -> slv_r_ready_o=0 and the beat is held. A slave R valid with an empty FIFO -> r_orphan_o=1, and no cbar valid asserted.
- With LITEIC_QOS_AGING_EN and AGE_PERIOD=4: a qos-0 slot competing with a continuous qos-1 stream -> granted after at most 8 stall cycles.
